fighter_state_ctrl: RTL and testbench
=====================================

Name: fighter_state_ctrl

Overview:
- Per-player character controller and the consuming end of the combat resolver's hit interface; one instance per player.
- Takes player buttons and the resolver outputs (hit_event, hitstun, kb_dx, kb_dy).
- Produces per frame: position, facing, the attack_damage window, health and KO status, all fed back to the resolver and the VGA renderer.
- All game state advances only on SCEN (one frame tick).

Parameters:
- POS_WIDTH, 10, position width.
- START_X, 100, reset/restart x.
- START_FACE_RIGHT, 1, reset/restart facing.
- X_MIN, 0, left clamp.
- X_MAX, 520, right clamp.
- GROUND_Y, 300, floor y; larger y is lower on screen.
- WALK_SPEED, 2, px/frame.
- JUMP_VY, -8, signed launch velocity.
- GRAVITY, 1, vy increment per airborne frame.
- MAX_HEALTH, 100, starting health, fits 8 bits.
- HIT_DAMAGE, 10, health lost per accepted hit.
- ATK_STARTUP, 4, startup frames, >=1.
- ATK_ACTIVE, 3, frames attack_damage is high, >=1.
- ATK_RECOVERY, 6, recovery frames, >=1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset: one clock; asynchronous, active-low.
- SCEN  in  1  frame-tick enable.
- restart  in  1  synchronous round restart, any cycle.
- btn_left, btn_right, btn_jump, btn_attack  in  1 each  debounced buttons, level.
- hit_event  in  1  resolver hit pulse for this player.
- hitstun  in  1  resolver stun level for this player.
- kb_dx, kb_dy  in  8 signed  resolver knockback.
- pos_x, pos_y  out  POS_WIDTH  sprite origin.
- face_right  out  1  facing.
- attack_damage  out  1  high during the ACTIVE state.
- health  out  8  remaining health.
- ko  out  1  high in KO.
- state_o  out  3  FSM state, for sprite selection.

Behaviour:
- Reset (reset_n low, async) and restart (sync, priority over SCEN) load the same values:
  - pos_x=START_X, pos_y=GROUND_Y, face_right=START_FACE_RIGHT, health=MAX_HEALTH.
  - vx=vy=0, on_ground=1, state=ACT, counter=0, attack_damage=0, ko=0.
  - Button history regs cleared.
- With SCEN=0, every register holds.
- Button edges: rise = btn & ~prev, evaluated at SCEN; prev is updated only at SCEN.
- States (state_o encoding): ACT=0, STARTUP=1, ACTIVE=2, RECOVERY=3, HITSTUN=4, KO=5.
- Priority per SCEN: hit > attack/jump start > counter advance.
- Accepted hit: hit_event=1 in ACT/STARTUP/ACTIVE/RECOVERY.
  - health = max(health - HIT_DAMAGE, 0).
  - vx = kb_dx (sign-extended); vy = kb_dy. If kb_dy < 0, on_ground=0.
  - attack_damage=0. Next state is HITSTUN, or KO if new health = 0.
- hit_event in HITSTUN or KO is ignored (no damage, no kb refresh).
- ACT:
  - vx = +WALK_SPEED if right only, -WALK_SPEED if left only, 0 if both or neither.
  - face_right is set by right-only or left-only; otherwise it holds.
  - Jump rise with on_ground: vy=JUMP_VY, on_ground=0, y unchanged this frame.
  - Attack rise with on_ground: go to STARTUP, counter=ATK_STARTUP-1. Attack while airborne is ignored.
- STARTUP/ACTIVE/RECOVERY:
  - vx=0; direction buttons ignored; facing frozen.
  - Each SCEN: counter-1. At counter 0, go to the next phase with counter=len-1; RECOVERY at 0 returns to ACT.
  - attack_damage is registered: high in exactly ATK_ACTIVE SCEN periods, starting ATK_STARTUP frames after the triggering frame.
- HITSTUN:
  - vx holds its knockback value.
  - Exit to ACT (vx=0) on the first SCEN with hitstun=0, hit_event=0 and on_ground=1. An airborne stunned player stays in HITSTUN until landing.
- KO: terminal until reset/restart. vx=0; gravity still applies.
- Horizontal update (every SCEN, all states):
  - x' = x + vx, computed signed at POS_WIDTH+2 bits.
  - Clamp to [X_MIN, X_MAX]; a clamped edge does not alter vx.
- Vertical update (every SCEN, when on_ground=0 and not the jump-launch frame):
  - If y+vy >= GROUND_Y: y=GROUND_Y, vy=0, on_ground=1.
  - Else: y = max(y+vy, 0), vy += GRAVITY.
- Simultaneous: hit arriving in the same frame as an attack or jump rise wins; the rise is discarded.

Test Plan:
- Walk: reset, hold btn_right 10 SCEN -> pos_x 100→120, face_right=1. Then hold both -> x holds. Walk left from x=1 -> x clamps at 0.
- Jump: btn_jump rise from ground -> y sequence 300(launch),292,285,279,274,270,267,265,264,264,265,267,270,274,279,285,292,300; on_ground=1 at the final frame.
- Attack: btn_attack rise at frame F -> state 1 at F+1..F+4, attack_damage=1 and state 2 exactly F+5..F+7, state 3 F+8..F+13, state 0 at F+14.
- Hit during ACTIVE, kb_dx=-4, kb_dy=-2 -> attack_damage drops next SCEN, health 100→90, state 4, x decreases 4/frame; a repeated hit_event while stunned leaves health at 90. Exit to ACT on the first grounded frame with hitstun=0.
- KO: HIT_DAMAGE=30, four accepted hits -> health 70,40,10,0; ko=1, state 5. A fifth hit_event and button presses -> no change. restart pulse -> all reset values.
- Async reset mid-air and mid-ACTIVE (reset_n low between clk edges) -> outputs at reset values immediately. SCEN held low 20 cycles -> no register changes.

Source files
------------

// File: rtl/fighter_state_ctrl.sv
// rtl/fighter_state_ctrl.sv - per-player fighter movement, attack and damage controller
// All game state advances on the SCEN frame tick; restart reloads the round start values.
module fighter_state_ctrl #(
  parameter int POS_WIDTH        = 10,
  parameter int START_X          = 100,
  parameter bit START_FACE_RIGHT = 1'b1,
  parameter int X_MIN            = 0,
  parameter int X_MAX            = 520,
  parameter int GROUND_Y         = 300,
  parameter int WALK_SPEED       = 2,
  parameter int JUMP_VY          = -8,
  parameter int GRAVITY          = 1,
  parameter int MAX_HEALTH       = 100,
  parameter int HIT_DAMAGE       = 10,
  parameter int ATK_STARTUP      = 4,
  parameter int ATK_ACTIVE       = 3,
  parameter int ATK_RECOVERY     = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 SCEN,
  input  logic                 restart,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_jump,
  input  logic                 btn_attack,
  input  logic                 hit_event,
  input  logic                 hitstun,
  input  logic signed [7:0]    kb_dx,
  input  logic signed [7:0]    kb_dy,
  output logic [POS_WIDTH-1:0] pos_x,
  output logic [POS_WIDTH-1:0] pos_y,
  output logic                 face_right,
  output logic                 attack_damage,
  output logic [7:0]           health,
  output logic                 ko,
  output logic [2:0]           state_o
);

  localparam int SW = POS_WIDTH + 2;
  localparam logic signed [SW-1:0]  X_MIN_S  = SW'(X_MIN);
  localparam logic signed [SW-1:0]  X_MAX_S  = SW'(X_MAX);
  localparam logic signed [SW-1:0]  GROUND_S = SW'(GROUND_Y);
  localparam logic [POS_WIDTH-1:0]  START_XP = POS_WIDTH'(START_X);
  localparam logic [POS_WIDTH-1:0]  GROUND_P = POS_WIDTH'(GROUND_Y);
  localparam logic [7:0]            HP_MAX   = 8'(MAX_HEALTH);
  localparam logic [7:0]            HP_DMG   = 8'(HIT_DAMAGE);

  typedef enum logic [2:0] {
    S_ACT      = 3'd0,
    S_STARTUP  = 3'd1,
    S_ACTIVE   = 3'd2,
    S_RECOVERY = 3'd3,
    S_HITSTUN  = 3'd4,
    S_KO       = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [POS_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic signed [7:0]      vx_q, vx_d, vy_q, vy_d;
  logic                   ground_q, ground_d;
  logic                   face_q, face_d;
  logic                   atk_q, atk_d;
  logic [7:0]             hp_q, hp_d;
  logic                   jump_prev_q, jump_prev_d;
  logic                   atk_prev_q, atk_prev_d;

  logic                   jump_rise, atk_rise, hit_ok, launch;
  logic [7:0]             hp_hit;
  logic signed [8:0]      vy_inc;
  logic signed [SW-1:0]   x_sum, y_sum;

  assign jump_rise = btn_jump & ~jump_prev_q;
  assign atk_rise  = btn_attack & ~atk_prev_q;
  assign hit_ok    = hit_event && (state_q inside {S_ACT, S_STARTUP, S_ACTIVE, S_RECOVERY});
  assign hp_hit    = (hp_q > HP_DMG) ? hp_q - HP_DMG : 8'd0;
  assign vy_inc    = {vy_q[7], vy_q} + 9'(GRAVITY);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    ground_d    = ground_q;
    face_d      = face_q;
    atk_d       = atk_q;
    hp_d        = hp_q;
    jump_prev_d = jump_prev_q;
    atk_prev_d  = atk_prev_q;
    launch      = 1'b0;
    x_sum       = '0;
    y_sum       = '0;

    if (restart) begin
      state_d     = S_ACT;
      cnt_d       = '0;
      x_d         = START_XP;
      y_d         = GROUND_P;
      vx_d        = '0;
      vy_d        = '0;
      ground_d    = 1'b1;
      face_d      = START_FACE_RIGHT;
      atk_d       = 1'b0;
      hp_d        = HP_MAX;
      jump_prev_d = 1'b0;
      atk_prev_d  = 1'b0;
    end else if (SCEN) begin
      jump_prev_d = btn_jump;
      atk_prev_d  = btn_attack;

      if (hit_ok) begin
        // A loaded knockback vy behaves like a launch: y holds on the hit frame.
        hp_d    = hp_hit;
        vx_d    = kb_dx;
        vy_d    = kb_dy;
        launch  = 1'b1;
        cnt_d   = '0;
        if (kb_dy[7]) ground_d = 1'b0;
        state_d = (hp_hit == 8'd0) ? S_KO : S_HITSTUN;
      end else begin
        case (state_q)
          S_ACT: begin
            if (btn_right && !btn_left) begin
              vx_d   = 8'(WALK_SPEED);
              face_d = 1'b1;
            end else if (btn_left && !btn_right) begin
              vx_d   = 8'(-WALK_SPEED);
              face_d = 1'b0;
            end else begin
              vx_d = '0;
            end
            if (jump_rise && ground_q) begin
              vy_d     = 8'(JUMP_VY);
              ground_d = 1'b0;
              launch   = 1'b1;
            end
            if (atk_rise && ground_q) begin
              state_d = S_STARTUP;
              cnt_d   = 8'(ATK_STARTUP - 1);
              vx_d    = '0;
            end
          end
          S_STARTUP: begin
            vx_d = '0;
            if (cnt_q == 8'd0) begin
              state_d = S_ACTIVE;
              cnt_d   = 8'(ATK_ACTIVE - 1);
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
          S_ACTIVE: begin
            vx_d = '0;
            if (cnt_q == 8'd0) begin
              state_d = S_RECOVERY;
              cnt_d   = 8'(ATK_RECOVERY - 1);
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
          S_RECOVERY: begin
            vx_d = '0;
            if (cnt_q == 8'd0) begin
              state_d = S_ACT;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
          S_HITSTUN: begin
            if (!hitstun && !hit_event && ground_q) begin
              state_d = S_ACT;
              vx_d    = '0;
            end
          end
          S_KO:    vx_d = '0;
          default: state_d = S_ACT;
        endcase
      end

      atk_d = (state_d == S_ACTIVE);

      x_sum = {2'b00, x_q} + {{(SW-8){vx_d[7]}}, vx_d};
      if (x_sum < X_MIN_S) begin
        x_d = POS_WIDTH'(X_MIN);
      end else if (x_sum > X_MAX_S) begin
        x_d = POS_WIDTH'(X_MAX);
      end else begin
        x_d = x_sum[POS_WIDTH-1:0];
      end

      if (!ground_q && !launch) begin
        y_sum = {2'b00, y_q} + {{(SW-8){vy_q[7]}}, vy_q};
        if (y_sum >= GROUND_S) begin
          y_d      = GROUND_P;
          vy_d     = '0;
          ground_d = 1'b1;
        end else begin
          y_d  = y_sum[SW-1] ? '0 : y_sum[POS_WIDTH-1:0];
          vy_d = (vy_inc > 9'sd127) ? 8'sd127 : vy_inc[7:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_ACT;
      cnt_q       <= '0;
      x_q         <= START_XP;
      y_q         <= GROUND_P;
      vx_q        <= '0;
      vy_q        <= '0;
      ground_q    <= 1'b1;
      face_q      <= START_FACE_RIGHT;
      atk_q       <= 1'b0;
      hp_q        <= HP_MAX;
      jump_prev_q <= 1'b0;
      atk_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      ground_q    <= ground_d;
      face_q      <= face_d;
      atk_q       <= atk_d;
      hp_q        <= hp_d;
      jump_prev_q <= jump_prev_d;
      atk_prev_q  <= atk_prev_d;
    end
  end

  assign pos_x         = x_q;
  assign pos_y         = y_q;
  assign face_right    = face_q;
  assign attack_damage = atk_q;
  assign health        = hp_q;
  assign ko            = (state_q == S_KO);
  assign state_o       = state_q;

endmodule

// File: tb/tb_fighter_state_ctrl.sv
// tb/tb_fighter_state_ctrl.sv - self-checking bench for fighter_state_ctrl
// Vector table, directed corner sequences, then random frames against a frame-level model.
module tb_fighter_state_ctrl;

  logic              clk = 1'b0;
  logic              reset_n, scen, restart;
  logic              bl, br, bj, ba, hev, hst;
  logic signed [7:0] kdx, kdy;
  logic [9:0]        pos_x, pos_y;
  logic              face_right, attack_damage, ko;
  logic [7:0]        health;
  logic [2:0]        state_o;

  always #5 clk = ~clk;

  fighter_state_ctrl dut (
    .clk(clk), .reset_n(reset_n), .SCEN(scen), .restart(restart),
    .btn_left(bl), .btn_right(br), .btn_jump(bj), .btn_attack(ba),
    .hit_event(hev), .hitstun(hst), .kb_dx(kdx), .kb_dy(kdy),
    .pos_x(pos_x), .pos_y(pos_y), .face_right(face_right),
    .attack_damage(attack_damage), .health(health), .ko(ko), .state_o(state_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit l, r, j, a, h, s, input int dx, input int dy);
    bl = l; br = r; bj = j; ba = a; hev = h; hst = s;
    kdx = 8'(dx); kdy = 8'(dy);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int ex, input int ey, input int est,
                         input int eatk, input int ehp);
    chk({tag, ".x"}, int'(pos_x), ex);
    chk({tag, ".y"}, int'(pos_y), ey);
    chk({tag, ".state"}, int'(state_o), est);
    chk({tag, ".atk"}, int'(attack_damage), eatk);
    chk({tag, ".hp"}, int'(health), ehp);
  endtask

  // Frame-level reference: phases tracked by elapsed frames rather than a countdown.
  int m_x, m_y, m_vx, m_vy, m_st, m_age, m_hp;
  bit m_gnd, m_face, m_pj, m_pa;

  function automatic int phase_len(input int st);
    return (st == 1) ? 4 : (st == 2) ? 3 : 6;
  endfunction

  task automatic model_reset();
    m_x = 100; m_y = 300; m_vx = 0; m_vy = 0; m_st = 0; m_age = 0; m_hp = 100;
    m_gnd = 1; m_face = 1; m_pj = 0; m_pa = 0;
  endtask

  task automatic model_step();
    bit jr, ar, g0, launch;
    int dx, dy;
    dx = kdx; dy = kdy;
    jr = bj && !m_pj; ar = ba && !m_pa;
    m_pj = bj; m_pa = ba;
    g0 = m_gnd; launch = 0;
    if (hev && m_st <= 3) begin
      m_hp = (m_hp > 10) ? m_hp - 10 : 0;
      m_vx = dx; m_vy = dy; launch = 1;
      if (dy < 0) m_gnd = 0;
      m_st = (m_hp == 0) ? 5 : 4;
    end else begin
      case (m_st)
        0: begin
          if (br && !bl) begin m_vx = 2; m_face = 1; end
          else if (bl && !br) begin m_vx = -2; m_face = 0; end
          else m_vx = 0;
          if (jr && g0) begin m_vy = -8; m_gnd = 0; launch = 1; end
          if (ar && g0) begin m_st = 1; m_age = 0; m_vx = 0; end
        end
        1, 2, 3: begin
          m_vx = 0;
          m_age++;
          if (m_age == phase_len(m_st)) begin
            m_st = (m_st == 3) ? 0 : m_st + 1;
            m_age = 0;
          end
        end
        4: if (!hst && !hev && g0) begin m_st = 0; m_vx = 0; end
        default: m_vx = 0;
      endcase
    end
    m_x = m_x + m_vx;
    if (m_x < 0) m_x = 0;
    if (m_x > 520) m_x = 520;
    if (!g0 && !launch) begin
      if (m_y + m_vy >= 300) begin
        m_y = 300; m_vy = 0; m_gnd = 1;
      end else begin
        m_y = (m_y + m_vy < 0) ? 0 : m_y + m_vy;
        m_vy = (m_vy + 1 > 127) ? 127 : m_vy + 1;
      end
    end
  endtask

  typedef struct {
    bit l, r, j, a;
    int ex, ey, est, eatk, eface;
  } vec_t;

  vec_t tbl[$];
  int   jump_y[18];

  task automatic add(input bit l, r, j, a, input int ex, ey, est, eatk, eface);
    vec_t v;
    v.l = l; v.r = r; v.j = j; v.a = a;
    v.ex = ex; v.ey = ey; v.est = est; v.eatk = eatk; v.eface = eface;
    tbl.push_back(v);
  endtask

  initial begin
    jump_y = '{300, 292, 285, 279, 274, 270, 267, 265, 264,
               264, 265, 267, 270, 274, 279, 285, 292, 300};
    for (int k = 1; k <= 10; k++) add(0, 1, 0, 0, 100 + 2 * k, 300, 0, 0, 1);
    for (int k = 0; k < 3; k++)   add(1, 1, 0, 0, 120, 300, 0, 0, 1);
    for (int k = 1; k <= 5; k++)  add(1, 0, 0, 0, 120 - 2 * k, 300, 0, 0, 0);
    add(0, 1, 0, 0, 112, 300, 0, 0, 1);
    add(0, 0, 0, 0, 112, 300, 0, 0, 1);
    for (int k = 0; k < 18; k++)  add(0, 0, 1, 0, 112, jump_y[k], 0, 0, 1);
    add(0, 0, 0, 0, 112, 300, 0, 0, 1);
    add(0, 0, 0, 1, 112, 300, 1, 0, 1);
    for (int k = 0; k < 3; k++)   add(1, 0, 0, 0, 112, 300, 1, 0, 1);
    for (int k = 0; k < 3; k++)   add(1, 0, 0, 0, 112, 300, 2, 1, 1);
    for (int k = 0; k < 6; k++)   add(1, 0, 0, 0, 112, 300, 3, 0, 1);
    add(0, 0, 0, 0, 112, 300, 0, 0, 1);

    reset_n = 1'b0; scen = 1'b0; restart = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 100, 300, 0, 0, 100);
    chk("reset.face", int'(face_right), 1);
    chk("reset.ko", int'(ko), 0);
    @(negedge clk) reset_n = 1'b1;

    scen = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].l, tbl[i].r, tbl[i].j, tbl[i].a, 0, 0, 0, 0);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].est, tbl[i].eatk, 100);
      chk($sformatf("vec%0d.face", i), int'(face_right), tbl[i].eface);
    end

    // Hit during ACTIVE, ignored re-hit while stunned, airborne stun, landing exit.
    drive(0, 0, 0, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    step();
    chk_all("hit.pre", 112, 300, 2, 1, 100);
    drive(0, 0, 0, 0, 1, 1, -4, -2); step(); chk_all("hit.f1", 108, 300, 4, 0, 90);
    drive(0, 0, 0, 0, 0, 1, 0, 0);   step(); chk_all("hit.f2", 104, 298, 4, 0, 90);
    drive(0, 0, 0, 0, 1, 1, 5, -5);  step(); chk_all("hit.f3", 100, 297, 4, 0, 90);
    drive(0, 0, 0, 0, 0, 1, 0, 0);   step(); chk_all("hit.f4", 96, 297, 4, 0, 90);
    drive(0, 0, 0, 0, 0, 0, 0, 0);   step(); chk_all("hit.f5", 92, 298, 4, 0, 90);
    step(); chk_all("hit.f6", 88, 300, 4, 0, 90);
    step(); chk_all("hit.f7", 88, 300, 0, 0, 90);

    // Drain health to KO, then KO is terminal until restart.
    for (int i = 1; i <= 9; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 0); step();
      chk_all($sformatf("ko.hit%0d", i), 88, 300, (i == 9) ? 5 : 4, 0, 90 - 10 * i);
      if (i < 9) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk($sformatf("ko.exit%0d", i), int'(state_o), 0);
      end
    end
    chk("ko.flag", int'(ko), 1);
    drive(0, 1, 1, 1, 1, 0, 7, -3);
    repeat (3) step();
    chk_all("ko.hold", 88, 300, 5, 0, 0);
    scen = 1'b0; restart = 1'b1; step(); restart = 1'b0;
    chk_all("restart", 100, 300, 0, 0, 100);
    chk("restart.face", int'(face_right), 1);
    chk("restart.ko", int'(ko), 0);
    scen = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    step(); chk_all("rst.launch", 100, 300, 0, 0, 100);
    step(); chk_all("rst.air1", 100, 292, 0, 0, 100);
    step(); chk_all("rst.air2", 100, 285, 0, 0, 100);

    // Async reset mid-air and mid-ACTIVE.
    #2 reset_n = 1'b0;
    #1 chk_all("areset.air", 100, 300, 0, 0, 100);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) reset_n = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step();
    chk_all("areset.pre", 100, 300, 2, 1, 100);
    #2 reset_n = 1'b0;
    #1 chk_all("areset.active", 100, 300, 0, 0, 100);
    @(negedge clk) reset_n = 1'b1;

    // SCEN low: nothing moves, and button history is frozen too.
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk_all("hold.pre", 100, 285, 0, 0, 100);
    scen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), 1, $urandom_range(0, 1), -9, -9);
      step();
      chk_all($sformatf("hold%0d", c), 100, 285, 0, 0, 100);
    end
    scen = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    step(); chk_all("hold.resume", 100, 279, 0, 0, 100);

    // Random frames against the model.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    scen = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 4) == 0) bl = ~bl;
      if ($urandom_range(0, 4) == 0) br = ~br;
      if ($urandom_range(0, 3) == 0) bj = ~bj;
      if ($urandom_range(0, 5) == 0) ba = ~ba;
      scen    = ($urandom_range(0, 9) < 7);
      restart = ($urandom_range(0, 249) == 0);
      hev     = ($urandom_range(0, 11) == 0);
      hst     = 1'($urandom_range(0, 1));
      kdx     = 8'(int'($urandom_range(0, 80)) - 40);
      kdy     = 8'(int'($urandom_range(0, 12)) - 6);
      if (restart) model_reset();
      else if (scen) model_step();
      step();
      chk("rnd.x", int'(pos_x), m_x);
      chk("rnd.y", int'(pos_y), m_y);
      chk("rnd.face", int'(face_right), int'(m_face));
      chk("rnd.atk", int'(attack_damage), (m_st == 2) ? 1 : 0);
      chk("rnd.hp", int'(health), m_hp);
      chk("rnd.ko", int'(ko), (m_st == 5) ? 1 : 0);
      chk("rnd.state", int'(state_o), m_st);
    end
    restart = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
